// File: rtl/tristate_link_transceiver.sv
// ============================================================================
// Module   : tristate_link_transceiver
// Purpose  : Half-duplex single-wire UART-style transceiver owning one
//            tristate bus line; optional even parity via TRISTATE_LINK_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tristate_link_transceiver #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int TURN_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err,
    output logic              busy,
    output logic              drive_en,
    inout  wire               bus
);

`ifdef TRISTATE_LINK_PARITY_EN
    localparam int FRAME_W = DATA_W + 3;
`else
    localparam int FRAME_W = DATA_W + 2;
`endif
    localparam int CNT_MAX = (CLKS_PER_BIT > TURN_CYCLES) ? CLKS_PER_BIT : TURN_CYCLES + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TX   = 2'd1,
        S_TURN = 2'd2,
        S_RX   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [FRAME_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]  rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_err_q, rx_err_d;
    logic               sync1_q, bus_s_q, bus_prev_q;
    logic               armed_q;
`ifdef TRISTATE_LINK_PARITY_EN
    logic               par_q, par_d;
`endif

    logic               w_bus_in;
    logic [FRAME_W-1:0] w_frame;
    logic               w_cnt_end;
    logic               w_mid;
    logic               w_last_bit;
    logic               w_rx_ok;

    // Anything other than a solid 0 on the wire (z, x) reads as the idle level.
    assign w_bus_in = (bus === 1'b0) ? 1'b0 : 1'b1;

`ifdef TRISTATE_LINK_PARITY_EN
    assign w_frame = {1'b1, ^tx_data, tx_data, 1'b0};
    assign w_rx_ok = bus_s_q && !par_q;
`else
    assign w_frame = {1'b1, tx_data, 1'b0};
    assign w_rx_ok = bus_s_q;
`endif

    assign w_cnt_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign w_mid      = (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1));
    assign w_last_bit = (bit_q == BIT_W'(FRAME_W - 1));

    assign tx_ready = (state_q == S_IDLE) && bus_s_q && armed_q;
    assign busy     = (state_q != S_IDLE);
    assign drive_en = (state_q == S_TX);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign bus      = drive_en ? tx_shift_q[0] : 1'bz;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
`ifdef TRISTATE_LINK_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                // A falling edge beats a pending handshake; tx_ready is low then anyway.
                if (bus_prev_q && !bus_s_q) begin
                    state_d = S_RX;
`ifdef TRISTATE_LINK_PARITY_EN
                    par_d   = 1'b0;
`endif
                end else if (tx_valid && tx_ready) begin
                    state_d    = S_TX;
                    tx_shift_d = w_frame;
                end
            end
            S_TX: begin
                if (w_cnt_end) begin
                    cnt_d      = '0;
                    tx_shift_d = {1'b1, tx_shift_q[FRAME_W-1:1]};
                    bit_d      = bit_q + 1'b1;
                    if (w_last_bit) begin
                        state_d = S_TURN;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TURN: begin
                if (cnt_q == CNT_W'(TURN_CYCLES)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RX: begin
                cnt_d = w_cnt_end ? '0 : cnt_q + 1'b1;
                if (w_mid) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == '0) begin
                        if (bus_s_q) begin
                            state_d = S_IDLE;
                        end
                    end else if (w_last_bit) begin
                        state_d = S_IDLE;
                        if (w_rx_ok) begin
                            rx_data_d  = rx_shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_err_d = 1'b1;
                        end
                    end else begin
                        if (bit_q <= BIT_W'(DATA_W)) begin
                            rx_shift_d = {bus_s_q, rx_shift_q[DATA_W-1:1]};
                        end
`ifdef TRISTATE_LINK_PARITY_EN
                        par_d = par_q ^ bus_s_q;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_shift_q <= '1;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            sync1_q    <= 1'b1;
            bus_s_q    <= 1'b1;
            bus_prev_q <= 1'b1;
            armed_q    <= 1'b0;
`ifdef TRISTATE_LINK_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            sync1_q    <= w_bus_in;
            bus_s_q    <= sync1_q;
            bus_prev_q <= bus_s_q;
            armed_q    <= 1'b1;
`ifdef TRISTATE_LINK_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tristate_link_transceiver.sv
// ============================================================================
// Module   : tb_tristate_link_transceiver
// Purpose  : Randomized self-checking bench for tristate_link_transceiver
//            (honours TRISTATE_LINK_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tristate_link_transceiver;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;
    localparam int TURN   = 2;
`ifdef TRISTATE_LINK_PARITY_EN
    localparam int FRAME_W = DATA_W + 3;
`else
    localparam int FRAME_W = DATA_W + 2;
`endif
    localparam int FRAME_CYC = FRAME_W * CPB;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_err;
    logic              busy;
    logic              drive_en;
    wire               bus;
    logic              tb_drv = 1'b0;
    logic              tb_bit = 1'b1;

    pullup pu (bus);
    assign bus = tb_drv ? tb_bit : 1'bz;

    always #5 clk = ~clk;

    tristate_link_transceiver #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CPB),
        .TURN_CYCLES (TURN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_err  (rx_err),
        .busy    (busy),
        .drive_en(drive_en),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_err = 0;
    int drv_cyc = 0;
    logic [DATA_W-1:0] exp_data = '0;

    always @(negedge clk) begin
        if (rx_valid) n_valid++;
        if (rx_err) n_err++;
        if (drive_en) drv_cyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, [even parity], stop.
    function automatic logic [FRAME_W-1:0] frame_of(input logic [DATA_W-1:0] d,
                                                    input logic stop_b, input logic par_flip);
        logic [FRAME_W-1:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) f[i+1] = d[i];
`ifdef TRISTATE_LINK_PARITY_EN
        f[DATA_W+1] = (^d) ^ par_flip;
`else
        if (par_flip) f[0] = 1'b0;
`endif
        f[FRAME_W-1] = stop_b;
        return f;
    endfunction

    task automatic drive_frame(input logic [FRAME_W-1:0] f, input bit collide);
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            // A stop level of 1 is left to the pull-up, like an open-drain peer.
            if ((i / CPB) == FRAME_W - 1 && f[FRAME_W-1]) begin
                tb_drv = 1'b0;
            end else begin
                tb_drv = 1'b1;
                tb_bit = f[i / CPB];
            end
            if (collide && i == 2) begin
                check("collide_ready", 64'(tx_ready), 64'd0);
                tx_data  = 8'h11;
                tx_valid = 1'b1;
            end
        end
        @(negedge clk);
        tb_drv = 1'b0;
    endtask

    task automatic capture_tx(input logic [DATA_W-1:0] d, input string tag);
        logic [FRAME_W-1:0]   f;
        logic [FRAME_CYC-1:0] obs;
        logic [FRAME_CYC-1:0] expw;
        int n;
        int drv_n;
        f = frame_of(d, 1'b1, 1'b0);
        n = 0;
        while (!drive_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, 64'(drive_en), 64'd1);
        tx_valid = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        drv_n = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            obs[i]  = (bus === 1'b1);
            expw[i] = f[i / CPB];
            if (drive_en) drv_n++;
            @(negedge clk);
        end
        check({tag, "_wave"}, 64'(obs), 64'(expw));
        check({tag, "_drv_cycles"}, 64'(drv_n), 64'(FRAME_CYC));
        check({tag, "_release"}, 64'({drive_en, bus === 1'b1}), 64'b01);
        n = 0;
        while (!tx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_turn"}, 64'(n), 64'(TURN + 1));
    endtask

    task automatic send_tx(input logic [DATA_W-1:0] d, input string tag);
        int n;
        n = 0;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 64'(tx_ready), 64'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        capture_tx(d, tag);
    endtask

    task automatic rx_frame(input logic [DATA_W-1:0] d, input logic stop_b,
                            input logic par_flip, input string tag);
        int v0;
        int e0;
        int d0;
        logic good;
        v0 = n_valid;
        e0 = n_err;
        d0 = drv_cyc;
        good = stop_b && !par_flip;
        drive_frame(frame_of(d, stop_b, par_flip), 1'b0);
        repeat (6) @(negedge clk);
        if (good) exp_data = d;
        check({tag, "_valid"}, 64'(n_valid - v0), good ? 64'd1 : 64'd0);
        check({tag, "_err"}, 64'(n_err - e0), good ? 64'd0 : 64'd1);
        check({tag, "_data"}, 64'(rx_data), 64'(exp_data));
        check({tag, "_nodrive"}, 64'(drv_cyc - d0), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int v0;
        int e0;
        int d0;
        logic [DATA_W-1:0] r;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bus_released", 64'(bus === 1'b1), 64'd1);
        check("rst_drive_en", 64'(drive_en), 64'd0);
        check("rst_tx_ready", 64'(tx_ready), 64'd0);
        check("rst_rx_data", 64'(rx_data), 64'd0);
        check("rst_pulses", 64'({rx_valid, rx_err}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        n = 0;
        while (!tx_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_ready_within_3", 64'(tx_ready && n <= 3), 64'd1);

        send_tx(8'hA5, "tx_a5");
        for (int k = 0; k < 4; k++) begin
            r = DATA_W'($urandom_range(0, 255));
            send_tx(r, "tx_rand");
        end

        rx_frame(8'h3C, 1'b1, 1'b0, "rx_3c");
        for (int k = 0; k < 4; k++) begin
            r = DATA_W'($urandom_range(0, 255));
            rx_frame(r, 1'b1, 1'b0, "rx_rand");
        end
        rx_frame(8'h3C, 1'b0, 1'b0, "rx_badstop");
`ifdef TRISTATE_LINK_PARITY_EN
        rx_frame(8'h3C, 1'b1, 1'b1, "rx_badpar");
        rx_frame(8'h5A, 1'b1, 1'b0, "rx_par_ok");
`endif

        v0 = n_valid;
        e0 = n_err;
        @(negedge clk);
        tb_drv = 1'b1;
        tb_bit = 1'b0;
        @(negedge clk);
        tb_drv = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_pulses", 64'((n_valid - v0) + (n_err - e0)), 64'd0);
        check("glitch_idle", 64'(busy), 64'd0);

        r = DATA_W'($urandom_range(0, 255));
        v0 = n_valid;
        d0 = drv_cyc;
        drive_frame(frame_of(r, 1'b1, 1'b0), 1'b1);
        check("collide_nodrive", 64'(drv_cyc - d0), 64'd0);
        capture_tx(8'h11, "collide_tx");
        exp_data = r;
        check("collide_rx_valid", 64'(n_valid - v0), 64'd1);
        check("collide_rx_data", 64'(rx_data), 64'(exp_data));

        n = 0;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        n = 0;
        while (!drive_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        repeat (3 * CPB + 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_drive_en", 64'(drive_en), 64'd0);
        check("midrst_bus", 64'(bus === 1'b1), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = n_valid;
        e0 = n_err;
        d0 = drv_cyc;
        repeat (60) @(negedge clk);
        check("midrst_no_pulses", 64'((n_valid - v0) + (n_err - e0)), 64'd0);
        check("midrst_no_drive", 64'(drv_cyc - d0), 64'd0);
        check("midrst_rx_data", 64'(rx_data), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
